// File: rtl/simd_pkg.sv
// Shared types and constants for the scalar/vector data-memory arbiter.
package simd_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 4;
  localparam int BEAT_W = $clog2(LANES);

  localparam int PORT_S = 0;
  localparam int PORT_V = 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a tie goes to the port named by r_prio, and every
// accepted grant hands priority to the other port.
module rr_arbiter2
  import simd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic r_prio;

  always_comb begin
    // NOTE: default assignment first so every path drives o_gnt; no latch is inferred.
    o_gnt = i_req;
    if (&i_req) begin
      o_gnt         = 2'b00;
      o_gnt[r_prio] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'(PORT_S);
    end else if (i_advance && (|o_gnt)) begin
      r_prio <= o_gnt[PORT_S];
    end
  end

endmodule

// File: rtl/simd_mem_arbiter.sv
// Shares one data-memory port between a 1-beat scalar path and a LANES-beat vector
// lane gather/scatter path; one transaction in flight at a time.
module simd_mem_arbiter
  import simd_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_done,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              v_req,
  input  logic              v_we,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [DATA_W-1:0] v_wdata,
  output logic              v_done,
  output logic [DATA_W-1:0] v_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LIDX_W = $clog2(DATA_W);

  state_e            r_state;
  logic              r_is_vec;
  logic              r_we;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_lanes;
  logic [BEAT_W-1:0] r_beat;

  logic [1:0]        w_gnt;
  logic              w_grant;
  logic              w_issue;
  logic              w_last;
  logic              w_src_vec;
  logic              w_src_we;
  logic [ADDR_W-1:0] w_src_base;
  logic [DATA_W-1:0] w_src_wdata;
  logic [BEAT_W-1:0] w_iss_beat;
  logic [LIDX_W-1:0] w_iss_lsb;
  logic [LIDX_W-1:0] w_cap_lsb;
  logic [ADDR_W-1:0] w_iss_addr;
  logic [DATA_W-1:0] w_iss_wdata;
  logic [DATA_W-1:0] w_lanes_next;

  assign w_grant = (r_state == IDLE) && (s_req || v_req);
  assign w_last  = !r_is_vec || (r_beat == BEAT_W'(LANES - 1));
  assign w_issue = w_grant || ((r_state == CAPTURE) && !w_last);

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     ({v_req, s_req}),
    .i_advance (w_grant),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    // The first beat issues straight from the granted request; later beats use the latched copy.
    w_src_vec   = r_is_vec;
    w_src_we    = r_we;
    w_src_base  = r_base;
    w_src_wdata = r_wdata;
    w_iss_beat  = r_beat + 1'b1;
    if (r_state == IDLE) begin
      w_src_vec   = w_gnt[PORT_V];
      w_src_we    = w_gnt[PORT_V] ? v_we    : s_we;
      w_src_base  = w_gnt[PORT_V] ? v_addr  : s_addr;
      w_src_wdata = w_gnt[PORT_V] ? v_wdata : s_wdata;
      w_iss_beat  = '0;
    end
    w_iss_lsb   = LIDX_W'(w_iss_beat) * LIDX_W'(LANE_W);
    w_cap_lsb   = LIDX_W'(r_beat) * LIDX_W'(LANE_W);
    w_iss_addr  = w_src_base + ADDR_W'(w_iss_beat);
    w_iss_wdata = w_src_wdata;
    if (w_src_vec) begin
      w_iss_wdata = DATA_W'(w_src_wdata[w_iss_lsb +: LANE_W]);
    end
    w_lanes_next = r_lanes;
    w_lanes_next[w_cap_lsb +: LANE_W] = mem_rdata[LANE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchronous reset clears datapath registers too, so every output reads 0 after reset.
      r_state   <= IDLE;
      r_is_vec  <= 1'b0;
      r_we      <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_lanes   <= '0;
      r_beat    <= '0;
      s_done    <= 1'b0;
      s_rdata   <= '0;
      v_done    <= 1'b0;
      v_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      // NOTE: defaults first; a later non-blocking assignment in this block overrides them.
      s_done    <= 1'b0;
      v_done    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;

      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_is_vec <= w_src_vec;
            r_we     <= w_src_we;
            r_base   <= w_src_base;
            r_wdata  <= w_src_wdata;
            busy     <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: r_state <= CAPTURE;
        CAPTURE: begin
          if (!r_we) begin
            if (r_is_vec) r_lanes <= w_lanes_next;
            else          s_rdata <= mem_rdata;
          end
          if (w_last) begin
            r_state <= DONE;
            if (r_is_vec) begin
              v_done <= 1'b1;
              if (!r_we) v_rdata <= w_lanes_next;
            end else begin
              s_done <= 1'b1;
            end
          end else begin
            r_state <= ISSUE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_issue) begin
        r_beat    <= w_iss_beat;
        mem_en    <= 1'b1;
        mem_we    <= w_src_we;
        mem_addr  <= w_iss_addr;
        mem_wdata <= w_src_we ? w_iss_wdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_simd_mem_arbiter.sv
// Randomized scoreboard bench for simd_mem_arbiter: a transaction-level model predicts
// every memory beat, every done response and the final memory image.
module tb_simd_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int LANE_W = 4;
  localparam int LANES  = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LMASK  = (1 << LANE_W) - 1;
  localparam int PS     = 0;
  localparam int PV     = 1;
  localparam int S_LAT  = 3;
  localparam int V_LAT  = 1 + 2 * LANES;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_req, s_we, v_req, v_we;
  logic [ADDR_W-1:0] s_addr, v_addr, mem_addr;
  logic [DATA_W-1:0] s_wdata, v_wdata, s_rdata, v_rdata, mem_wdata, mem_rdata;
  logic              s_done, v_done, mem_en, mem_we, busy;

  simd_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_done(s_done), .s_rdata(s_rdata),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_done(v_done), .v_rdata(v_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data RAM with 1-cycle read latency; read data is garbage when no read was issued.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              bd_we;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    else mem_rdata <= DATA_W'($urandom);
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  typedef struct packed {
    logic              load;
    logic [DATA_W-1:0] data;
  } resp_t;

  acc_t              acc_q[$];
  resp_t             s_q[$];
  resp_t             v_q[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                model_prio;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model of one granted transaction: expected beats, response and memory effect.
  task automatic push_txn(input int port, input logic we, input logic [ADDR_W-1:0] base,
                          input logic [DATA_W-1:0] wdata, input int beats_seen,
                          input bit expect_done);
    int                nb;
    logic [DATA_W-1:0] rd;
    resp_t             r;
    nb = (port == PV) ? LANES : 1;
    rd = '0;
    for (int i = 0; i < nb; i++) begin
      int                a;
      logic [DATA_W-1:0] wd;
      acc_t              e;
      a  = (int'(base) + i) % DEPTH;
      wd = (port == PV) ? DATA_W'((wdata >> (LANE_W * i)) & LMASK) : wdata;
      if (i < beats_seen) begin
        e.we    = we;
        e.addr  = ADDR_W'(a);
        e.wdata = wd;
        acc_q.push_back(e);
        if (we) model_mem[a] = wd;
        else if (port == PV) rd = rd | (DATA_W'(model_mem[a] & LMASK) << (LANE_W * i));
        else rd = model_mem[a];
      end
    end
    r.load = !we;
    r.data = rd;
    if (expect_done) begin
      if (port == PS) s_q.push_back(r);
      else v_q.push_back(r);
    end
    model_prio = 1 - port;
  endtask

  // Monitor: compares every bus cycle and every done pulse against the scoreboard.
  int    cyc = 0;
  int    start_cyc = 0;
  logic  prev_busy = 1'b0;
  bit    mon_on = 1'b0;
  acc_t  mon_a;
  resp_t mon_r;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (busy && !prev_busy) start_cyc = cyc;
      prev_busy = busy;
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          check("unexpected_mem_beat", {mem_we, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          mon_a = acc_q.pop_front();
          check("beat_we", mem_we, mon_a.we);
          check("beat_addr", mem_addr, mon_a.addr);
          if (mon_a.we) check("beat_wdata", mem_wdata, mon_a.wdata);
        end
      end else begin
        check("quiet_bus", {mem_we, mem_addr, mem_wdata}, 0);
      end
      if (s_done) begin
        if (s_q.size() == 0) begin
          check("unexpected_s_done", s_done, 0);
        end else begin
          mon_r = s_q.pop_front();
          if (mon_r.load) check("s_rdata", s_rdata, mon_r.data);
          check("s_latency", cyc - start_cyc + 1, S_LAT);
        end
      end
      if (v_done) begin
        if (v_q.size() == 0) begin
          check("unexpected_v_done", v_done, 0);
        end else begin
          mon_r = v_q.pop_front();
          if (mon_r.load) check("v_rdata", v_rdata, mon_r.data);
          check("v_latency", cyc - start_cyc + 1, V_LAT);
        end
      end
    end
  end

  task automatic poke(input int a, input logic [DATA_W-1:0] d);
    bd_we   = 1'b1;
    bd_addr = ADDR_W'(a);
    bd_data = d;
    model_mem[a] = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  task automatic drive(input int port, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    if (port == PS) begin
      s_we = we; s_addr = a; s_wdata = d; s_req = 1'b1;
    end else begin
      v_we = we; v_addr = a; v_wdata = d; v_req = 1'b1;
    end
  endtask

  task automatic wait_done(input int port, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = (port == PV) ? v_done : s_done;
    end
    check({name, "_done_seen"}, 32'(seen), 1);
  endtask

  // The requester drops req on the edge that ends its done cycle.
  task automatic release_req(input int port);
    @(posedge clk);
    #1;
    if (port == PS) s_req = 1'b0;
    else v_req = 1'b0;
  endtask

  task automatic do_single(input int port, input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit drop, input string name);
    push_txn(port, we, a, d, LANES, 1'b1);
    drive(port, we, a, d);
    if (drop) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      if (port == PS) s_req = 1'b0;
      else v_req = 1'b0;
    end
    wait_done(port, name);
    if (!drop) release_req(port);
  endtask

  task automatic do_pair(input logic swe, input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                         input logic vwe, input logic [ADDR_W-1:0] va, input logic [DATA_W-1:0] vd,
                         input string name);
    int first;
    first = model_prio;
    if (first == PS) begin
      push_txn(PS, swe, sa, sd, 1, 1'b1);
      push_txn(PV, vwe, va, vd, LANES, 1'b1);
    end else begin
      push_txn(PV, vwe, va, vd, LANES, 1'b1);
      push_txn(PS, swe, sa, sd, 1, 1'b1);
    end
    drive(PS, swe, sa, sd);
    drive(PV, vwe, va, vd);
    wait_done(first, {name, "_first"});
    release_req(first);
    wait_done(1 - first, {name, "_second"});
    release_req(1 - first);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                seen;
    int                kind;
    int                first;
    logic              r_swe, r_vwe;
    logic [ADDR_W-1:0] r_sa, r_va;
    logic [DATA_W-1:0] r_sd, r_vd;

    rst = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    v_req = 1'b0; v_we = 1'b0; v_addr = '0; v_wdata = '0;
    for (int i = 0; i < DEPTH; i++) poke(i, DATA_W'($urandom));

    @(negedge clk);
    check("reset_ctrl", {s_done, v_done, mem_en, mem_we, busy, mem_addr}, 0);
    check("reset_s_rdata", s_rdata, 0);
    check("reset_v_rdata", v_rdata, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_prio = PS;
    mon_on = 1'b1;

    // Scalar load
    poke(5, 16'hBEEF);
    do_single(PS, 1'b0, 4'd5, '0, 1'b0, "t1");
    check("t1_s_rdata_const", s_rdata, 16'hBEEF);

    // Vector load: lane i from the low nibble of mem[8+i]
    for (int i = 0; i < LANES; i++) poke(8 + i, {12'($urandom), 4'(i + 1)});
    do_single(PV, 1'b0, 4'd8, '0, 1'b0, "t2");
    check("t2_v_rdata_const", v_rdata, 16'h4321);

    // Vector store wrapping past the top of memory
    do_single(PV, 1'b1, 4'd14, 16'hDCBA, 1'b0, "t3");
    check("t3_mem14", mem[14], 16'h000A);
    check("t3_mem15", mem[15], 16'h000B);
    check("t3_mem0", mem[0], 16'h000C);
    check("t3_mem1", mem[1], 16'h000D);

    // Reset during beat 2 of a VLOAD
    r_va = ADDR_W'($urandom);
    push_txn(PV, 1'b0, r_va, '0, 3, 1'b0);
    drive(PV, 1'b0, r_va, '0);
    seen = 0;
    for (int i = 0; i < 30 && seen < 3; i++) begin
      @(negedge clk);
      if (mem_en) seen++;
    end
    check("t5_beats_before_reset", seen, 3);
    rst = 1'b1;
    v_req = 1'b0;
    model_prio = PS;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_mem_en", mem_en, 0);
    check("t5_busy", busy, 0);
    check("t5_v_done", v_done, 0);
    check("t5_pending_beats", acc_q.size(), 0);
    repeat (12) @(posedge clk);
    #1;

    // Ties: first after reset, then again after a lone scalar
    do_pair(1'b0, 4'd3, '0, 1'b0, 4'd6, '0, "t4a");
    do_single(PS, 1'b1, 4'd2, 16'h1234, 1'b0, "t4b");
    do_pair(1'b0, 4'd2, '0, 1'b1, 4'd9, 16'h5A3C, "t4c");

    // Held scalar req with a vector request arriving meanwhile
    r_sa = ADDR_W'($urandom);
    r_va = ADDR_W'($urandom);
    r_vd = DATA_W'($urandom);
    push_txn(PS, 1'b0, r_sa, '0, 1, 1'b1);
    drive(PS, 1'b0, r_sa, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive(PV, 1'b1, r_va, r_vd);
    first = model_prio;
    if (first == PV) begin
      push_txn(PV, 1'b1, r_va, r_vd, LANES, 1'b1);
      push_txn(PS, 1'b0, r_sa, '0, 1, 1'b1);
    end else begin
      push_txn(PS, 1'b0, r_sa, '0, 1, 1'b1);
      push_txn(PV, 1'b1, r_va, r_vd, LANES, 1'b1);
    end
    wait_done(PS, "t6_first_s");
    wait_done(first, "t6_second");
    release_req(first);
    wait_done(1 - first, "t6_third");
    release_req(1 - first);

    // Randomized traffic
    for (int r = 0; r < 30; r++) begin
      kind  = $urandom_range(0, 2);
      r_swe = 1'($urandom);
      r_vwe = 1'($urandom);
      r_sa  = ADDR_W'($urandom);
      r_va  = ADDR_W'($urandom);
      r_sd  = DATA_W'($urandom);
      r_vd  = DATA_W'($urandom);
      if (kind == 0) do_single(PS, r_swe, r_sa, r_sd, ($urandom_range(0, 3) == 0), "rnd_s");
      else if (kind == 1) do_single(PV, r_vwe, r_va, r_vd, ($urandom_range(0, 3) == 0), "rnd_v");
      else do_pair(r_swe, r_sa, r_sd, r_vwe, r_va, r_vd, "rnd_pair");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (20) @(negedge clk);
    check("end_beats_left", acc_q.size(), 0);
    check("end_s_left", s_q.size(), 0);
    check("end_v_left", v_q.size(), 0);
    for (int i = 0; i < DEPTH; i++) check("end_mem_image", mem[i], model_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
